// File: rtl/matching_point_seq_if.sv
// Result beat stream from the matching-point sequencer to the downstream matcher.
// One beat carries the captured datapath points for a single tau.
interface matching_point_seq_if #(
  parameter int WIDTH = 14
);
  logic               out_valid;
  logic               out_ready;
  logic [4*WIDTH-1:0] out_xi;
  logic [4*WIDTH-1:0] out_yi;
  logic [4*WIDTH-1:0] out_xo;
  logic [4*WIDTH-1:0] out_yo;
  logic [WIDTH-1:0]   out_xb;
  logic [WIDTH-1:0]   out_yb;
  logic [7:0]         out_tau;
  logic               out_last;

  modport master (
    output out_valid, out_xi, out_yi, out_xo, out_yo, out_xb, out_yb, out_tau, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_xi, out_yi, out_xo, out_yo, out_xb, out_yb, out_tau, out_last,
    output out_ready
  );
endinterface

// File: rtl/matching_point_seq.sv
// Sequencer for the matching-point datapath: latches one eye-parameter set, sweeps tau,
// waits the datapath latency per point and streams the captured results out.
module matching_point_seq #(
  parameter int WIDTH    = 14,
  parameter int NUM_TAU  = 64,
  parameter int TAU_STEP = 4,
  parameter int LAT      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [11:0]        theta_in,
  input  logic [11:0]        phi_in,
  input  logic [11:0]        alpha_in,
  input  logic [13:0]        xc_in,
  input  logic [13:0]        yc_in,
  input  logic [12:0]        rE_in,
  output logic [11:0]        dp_theta,
  output logic [11:0]        dp_phi,
  output logic [11:0]        dp_alpha,
  output logic [13:0]        dp_xc,
  output logic [13:0]        dp_yc,
  output logic [12:0]        dp_rE,
  output logic [7:0]         dp_tau,
  input  logic [4*WIDTH-1:0] dp_new_xi,
  input  logic [4*WIDTH-1:0] dp_new_yi,
  input  logic [4*WIDTH-1:0] dp_new_xo,
  input  logic [4*WIDTH-1:0] dp_new_yo,
  input  logic [WIDTH-1:0]   dp_xb,
  input  logic [WIDTH-1:0]   dp_yb,
  matching_point_seq_if.master out_if,
  output logic               busy,
  output logic               done
);

  localparam int IDX_W = $clog2(NUM_TAU + 1);
  localparam int CNT_W = $clog2(LAT + 1);
  localparam int PAR_W = 3 * 12 + 2 * 14 + 13;
  localparam int PTS_W = 18 * WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAU - 1);
  localparam logic [CNT_W-1:0] LAT_CNT  = CNT_W'(LAT);
  localparam logic [7:0]       STEP8    = 8'(TAU_STEP);

  typedef enum logic [1:0] {IDLE, SETTLE, EMIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PAR_W-1:0]   par_q, par_d;
  logic [7:0]         tau_q, tau_d;
  logic               vld_q, vld_d;
  logic               last_q, last_d;
  logic [7:0]         otau_q, otau_d;
  logic [PTS_W-1:0]   pts_q, pts_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      par_q   <= '0;
      tau_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      otau_q  <= '0;
      pts_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tau_q   <= tau_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      otau_q  <= otau_d;
      pts_q   <= pts_d;
    end
  end

  // The settle counter runs LAT down to 0 and the capture happens on the edge after it
  // reaches 0, giving LAT+1 clocks from a stable tau to a valid beat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    par_d   = par_q;
    tau_d   = tau_q;
    vld_d   = vld_q;
    last_d  = last_q;
    otau_d  = otau_q;
    pts_d   = pts_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          par_d   = {theta_in, phi_in, alpha_in, xc_in, yc_in, rE_in};
          tau_d   = '0;
          idx_d   = '0;
          cnt_d   = LAT_CNT;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          pts_d   = {dp_new_xi, dp_new_yi, dp_new_xo, dp_new_yo, dp_xb, dp_yb};
          otau_d  = tau_q;
          last_d  = (idx_q == LAST_IDX);
          vld_d   = 1'b1;
          state_d = EMIT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      EMIT: begin
        // Abort wins over a handshake on the same edge.
        if (abort) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end else if (vld_q && out_if.out_ready) begin
          vld_d = 1'b0;
          if (last_q) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            tau_d   = tau_q + STEP8;
            cnt_d   = LAT_CNT;
            state_d = SETTLE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign {dp_theta, dp_phi, dp_alpha, dp_xc, dp_yc, dp_rE} = par_q;
  assign dp_tau = tau_q;

  assign {out_if.out_xi, out_if.out_yi, out_if.out_xo, out_if.out_yo,
          out_if.out_xb, out_if.out_yb} = pts_q;
  assign out_if.out_valid = vld_q;
  assign out_if.out_tau   = otau_q;
  assign out_if.out_last  = last_q;

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: doc/matching_point_seq.md
Name: matching_point_seq

Overview:
- Sequencer for the matching-point datapath (iris-centre, boundary and point-calculation chain).
- On a start request it latches one eye-parameter set, sweeps the boundary sample index tau over NUM_TAU points, and waits the datapath's fixed latency for each point.
- It then captures the datapath results and presents them one point at a time on a valid/ready output stream to the downstream matcher.

Parameters:
- WIDTH, 14, width of each coordinate word returned by the datapath
- NUM_TAU, 64, number of tau points per sweep (1..256)
- TAU_STEP, 4, tau increment between points, modulo 256
- LAT, 8, datapath settle latency in clocks, from a stable tau to valid results (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  sweep request pulse; sampled only in IDLE
- abort  in  1  cancel the sweep in progress
- theta_in  in  12  gaze angle theta
- phi_in  in  12  gaze angle phi
- alpha_in  in  12  rotation alpha
- xc_in  in  14  eye-centre x
- yc_in  in  14  eye-centre y
- rE_in  in  13  eyeball radius
- dp_theta  out  12  latched theta to datapath
- dp_phi  out  12  latched phi to datapath
- dp_alpha  out  12  latched alpha to datapath
- dp_xc  out  14  latched xc to datapath
- dp_yc  out  14  latched yc to datapath
- dp_rE  out  13  latched rE to datapath
- dp_tau  out  8  current tau to datapath
- dp_new_xi, dp_new_yi, dp_new_xo, dp_new_yo  in  4*WIDTH each  datapath point results
- dp_xb, dp_yb  in  WIDTH each  datapath boundary point
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts beat
- out_xi, out_yi, out_xo, out_yo  out  4*WIDTH each  captured points
- out_xb, out_yb  out  WIDTH each  captured boundary point
- out_tau  out  8  tau of the current beat
- out_last  out  1  beat is the final point of the sweep
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse on sweep completion

Behaviour:
- Reset: state IDLE; all outputs and internal registers 0 (dp_* 0, out_* 0, out_valid 0, busy 0, done 0).
- States: IDLE, SETTLE, EMIT, DONE. busy=1 in SETTLE, EMIT and DONE.
- IDLE, start=1 at an edge:
  - latch theta_in..rE_in into dp_*; dp_tau=0; idx=0; settle counter=LAT; go to SETTLE.
- SETTLE:
  - counter decrements each clock.
  - On the edge where the counter would reach 0, capture dp_new_*, dp_xb and dp_yb into out_*; out_tau=dp_tau; out_last=(idx==NUM_TAU-1); out_valid=1; go to EMIT.
  - Net timing: out_valid is high LAT+1 clocks after the triggering start or handshake edge.
- EMIT:
  - out_* and out_valid are held stable while out_ready=0.
  - On out_valid&out_ready: out_valid=0.
  - If out_last: go to DONE, done=1.
  - Else: idx+=1, dp_tau=(dp_tau+TAU_STEP) mod 256, counter=LAT, go to SETTLE.
- DONE: lasts 1 clock; done returns to 0; go to IDLE. Latched dp_* values are retained.
- With out_ready tied high, the beat period is LAT+2 clocks. Sweep length is NUM_TAU beats.
- dp_theta..dp_rE never change between start and return to IDLE. Input changes mid-sweep are ignored.
- start outside IDLE is ignored and does not queue.
- abort in any non-IDLE state: next edge goes to IDLE, out_valid=0, busy=0, and done is not pulsed. abort has priority over a simultaneous handshake. abort in IDLE with start has priority, so start is ignored.
- rst has priority over everything, and rst mid-sweep returns all outputs to reset values.
- NUM_TAU=1: the single beat has out_last=1.
- idx counts 0..NUM_TAU-1 using ceil(log2(NUM_TAU+1)) bits.

Test Plan:
- NUM_TAU=4, TAU_STEP=8, LAT=3, out_ready=1, start at edge k -> beats carry out_tau 0,8,16,24; first out_valid after edge k+4; out_last only on tau=24; done pulses once; dp_* equal the inputs latched at edge k.
- Same configuration, out_ready held 0 for 10 cycles on beat 2 -> out_valid and all out_* constant for those cycles; dp_tau stays 8; sweep resumes correctly afterwards.
- Change theta_in and xc_in mid-sweep, and pulse start during SETTLE -> dp_theta and dp_xc unchanged; no restart; exactly 4 beats.
- TAU_STEP=96, NUM_TAU=4 -> out_tau 0,96,192,32, confirming modulo-256 wrap.
- abort asserted during the second SETTLE -> IDLE next edge; out_valid=0; busy=0; no done. A new start then begins again at tau=0.
- rst asserted in EMIT with out_ready=1 -> all outputs 0 next edge; no done pulse; state IDLE.
